ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic.
- Sits directly upstream of the execute ALU and drives its a, b and alu_op inputs.
- Captures decoded instructions from ID, resolves RAW hazards from MEM/WB, and inserts bubbles or holds under stall/flush control.

Parameters:
- DATA_W, 32, datapath width (ALU operand width).
- REG_AW, 5, register-index width (x0 is hard-wired zero).

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- stall_i in 1: downstream stall; hold the EX register.
- flush_i in 1: taken branch/redirect; kill the instruction entering EX.
- id_valid in 1: ID holds a valid instruction.
- id_rs1, id_rs2 in REG_AW: source register indices.
- id_rd in REG_AW: destination register index.
- id_rs1_data, id_rs2_data in DATA_W: register-file read data.
- id_imm in DATA_W: sign-extended immediate, or raw 20-bit upper immediate for the load-upper-immediate op.
- id_use_imm in 1: ALU b takes the immediate instead of rs2.
- id_uses_rs2 in 1: instruction reads rs2 (R-type, branch, store).
- id_alu_op in 4: ALU operation code.
- id_reg_wr in 1: writes rd.
- id_mem_rd in 1: load instruction.
- mem_rd in REG_AW; mem_reg_wr in 1; mem_result in DATA_W: MEM-stage writeback info.
- wb_rd in REG_AW; wb_reg_wr in 1; wb_data in DATA_W: WB-stage writeback info.
- ex_valid out 1: EX holds a valid instruction.
- alu_a, alu_b out DATA_W: forwarded ALU operands.
- alu_op out 4: registered op.
- ex_rd out REG_AW; ex_reg_wr out 1; ex_mem_rd out 1: registered control.
- ex_store_data out DATA_W: forwarded rs2, regardless of use_imm.
- id_stall_o out 1: combinational request to freeze PC/IF/ID.

Behaviour:
- Reset: ex_valid, ex_reg_wr, ex_mem_rd, alu_op, ex_rd and all data registers are 0. alu_a, alu_b and ex_store_data are therefore 0.
- Latency: one cycle from ID capture to the EX outputs.
- EX-register update priority at each posedge: flush_i > stall_i > hazard > load.
  - flush_i: ex_valid <= 0, ex_reg_wr <= 0, ex_mem_rd <= 0 (bubble). Applies even if stall_i=1.
  - stall_i: all fields hold, except that the rs1/rs2 data registers capture the current forwarded values. A MEM/WB producer that retires during the stall is not lost.
  - Hazard: insert a bubble (valid/reg_wr/mem_rd = 0).
  - Otherwise load all ID fields, with ex_valid <= id_valid.
- Hazard (load-use) = ex_valid & ex_mem_rd & id_valid & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
- id_stall_o = (hazard | stall_i) & ~flush_i. Exactly one bubble is inserted per load-use hazard.
- Forwarding, per source, combinational on registered indices:
  - If index == 0: use 0.
  - Else if mem_reg_wr & mem_rd == idx: use mem_result (MEM has priority).
  - Else if wb_reg_wr & wb_rd == idx: use wb_data.
  - Else use the registered data.
- alu_a = fwd_rs1. alu_b = ex_use_imm ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2.
- Branch ops (alu_op[3:2] = 2'b11) must have use_imm = 0. The issue stage does not check this; decode guarantees it.
- Reset asserted mid-stall or mid-flush: everything clears asynchronously and id_stall_o deasserts immediately.

Decomposition:
- Package exec_pkg:
  - DATA_W and REG_AW localparams.
  - ALU op constants: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, MUL 1001, LUI 1010, BEQ 1100, BNE 1101, BGT 1110, BLT 1111.
  - Packed struct id_ex_t holding the registered fields.
- Sub-module fwd_mux: one instance per source; inputs are index, registered data, and the MEM/WB ports; output is the forwarded value.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with valid data in EX → all outputs 0 and id_stall_o=0 asynchronously.
- ADD with rs1=x1 (0x5), rs2=x2 (0x7), no hazards → next cycle alu_a=5, alu_b=7, alu_op=0000, ex_valid=1.
- MEM forwarding: EX ADD reads x3; mem_rd=3, mem_result=0xAA; wb_rd=3, wb_data=0xBB → alu_a=0xAA. With mem_reg_wr=0 → alu_a=0xBB. With rs1=x0 → alu_a=0 regardless of forwarding.
- Load-use: EX holds a load with rd=x4; ID instruction reads x4 via rs2 → id_stall_o=1 for one cycle, then a bubble (ex_valid=0), then the instruction issues and receives x4 via MEM forwarding.
- Stall retention: stall_i=1 for 3 cycles; WB writes x6=0x123 in cycle 1 only → alu_a stays 0x123 through cycles 2–3 and after release.
- Flush priority: flush_i=1 together with stall_i=1 and a hazard → next cycle ex_valid=0, ex_reg_wr=0, and id_stall_o=0 during the flush cycle.

Source files
------------

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared widths, ALU op codes and the ID/EX register layout.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_XOR = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_AND = 4'b0100;
    localparam logic [3:0] c_ALU_SLL = 4'b0101;
    localparam logic [3:0] c_ALU_SRL = 4'b0110;
    localparam logic [3:0] c_ALU_SRA = 4'b0111;
    localparam logic [3:0] c_ALU_SLT = 4'b1000;
    localparam logic [3:0] c_ALU_MUL = 4'b1001;
    localparam logic [3:0] c_ALU_LUI = 4'b1010;
    localparam logic [3:0] c_ALU_BEQ = 4'b1100;
    localparam logic [3:0] c_ALU_BNE = 4'b1101;
    localparam logic [3:0] c_ALU_BGT = 4'b1110;
    localparam logic [3:0] c_ALU_BLT = 4'b1111;

    typedef struct packed {
        logic              valid;
        logic              reg_wr;
        logic              mem_rd;
        logic              use_imm;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Operand bypass select for one source: x0, MEM, WB, or regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_wr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_wr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] fwd_data
);

    // MEM is the younger producer, so it wins over WB
    always_comb begin
        fwd_data = reg_data;
        if (idx == '0) begin
            fwd_data = '0;
        end else if (mem_reg_wr && (mem_rd == idx)) begin
            fwd_data = mem_result;
        end else if (wb_reg_wr && (wb_rd == idx)) begin
            fwd_data = wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_issue_stage
// Description : ID/EX register with MEM/WB operand forwarding and load-use stall.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_issue_stage #(
    parameter int DATA_W = exec_pkg::DATA_W,
    parameter int REG_AW = exec_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_uses_rs2,
    input  logic [3:0]        id_alu_op,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_wr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_wr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_wr,
    output logic              ex_mem_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              id_stall_o
);
    import exec_pkg::*;

    id_ex_t            r_ex;
    id_ex_t            w_id;
    logic              w_hazard;
    logic [REG_AW-1:0] w_src_idx  [2];
    logic [DATA_W-1:0] w_src_data [2];
    logic [DATA_W-1:0] w_fwd      [2];

    always_comb begin
        w_id          = '0;
        w_id.valid    = id_valid;
        w_id.reg_wr   = id_reg_wr;
        w_id.mem_rd   = id_mem_rd;
        w_id.use_imm  = id_use_imm;
        w_id.alu_op   = id_alu_op;
        w_id.rd       = id_rd;
        w_id.rs1      = id_rs1;
        w_id.rs2      = id_rs2;
        w_id.rs1_data = id_rs1_data;
        w_id.rs2_data = id_rs2_data;
        w_id.imm      = id_imm;
    end

    assign w_src_idx[0]  = r_ex.rs1;
    assign w_src_idx[1]  = r_ex.rs2;
    assign w_src_data[0] = r_ex.rs1_data;
    assign w_src_data[1] = r_ex.rs2_data;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_mux #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW)
        ) u_fwd_mux (
            .idx        (w_src_idx[gi]),
            .reg_data   (w_src_data[gi]),
            .mem_rd     (mem_rd),
            .mem_reg_wr (mem_reg_wr),
            .mem_result (mem_result),
            .wb_rd      (wb_rd),
            .wb_reg_wr  (wb_reg_wr),
            .wb_data    (wb_data),
            .fwd_data   (w_fwd[gi])
        );
    end

    // A load in EX cannot forward its data until MEM, so the consumer waits one cycle
    assign w_hazard = r_ex.valid & r_ex.mem_rd & id_valid & (r_ex.rd != '0) &
                      ((r_ex.rd == id_rs1) | (id_uses_rs2 & (r_ex.rd == id_rs2)));

    assign id_stall_o = (w_hazard | stall_i) & ~flush_i & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (flush_i) begin
            r_ex.valid  <= 1'b0;
            r_ex.reg_wr <= 1'b0;
            r_ex.mem_rd <= 1'b0;
        end else if (stall_i) begin
            // Keep any producer that retires while we are frozen
            r_ex.rs1_data <= w_fwd[0];
            r_ex.rs2_data <= w_fwd[1];
        end else if (w_hazard) begin
            r_ex.valid  <= 1'b0;
            r_ex.reg_wr <= 1'b0;
            r_ex.mem_rd <= 1'b0;
        end else begin
            r_ex <= w_id;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_reg_wr     = r_ex.reg_wr;
    assign ex_mem_rd     = r_ex.mem_rd;
    assign alu_op        = r_ex.alu_op;
    assign ex_rd         = r_ex.rd;
    assign alu_a         = w_fwd[0];
    assign alu_b         = r_ex.use_imm ? r_ex.imm : w_fwd[1];
    assign ex_store_data = w_fwd[1];

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_issue_stage
// Description : Scoreboard bench for ex_issue_stage with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_issue_stage;

    localparam int MA = 'h1FF;  // every field
    localparam int MB = 'h107;  // valid, reg_wr, mem_rd, stall only

    logic        clk, rst_n, stall_i, flush_i, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_result, wb_data;
    logic        id_use_imm, id_uses_rs2, id_reg_wr, id_mem_rd, mem_reg_wr, wb_reg_wr;
    logic [3:0]  id_alu_op, alu_op;
    logic        ex_valid, ex_reg_wr, ex_mem_rd, id_stall_o;
    logic [31:0] alu_a, alu_b, ex_store_data;

    typedef struct {
        int          mask;
        logic        valid;
        logic        rw;
        logic        mr;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic        stl;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    ex_issue_stage u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_use_imm    (id_use_imm),
        .id_uses_rs2   (id_uses_rs2),
        .id_alu_op     (id_alu_op),
        .id_reg_wr     (id_reg_wr),
        .id_mem_rd     (id_mem_rd),
        .mem_rd        (mem_rd),
        .mem_reg_wr    (mem_reg_wr),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_wr     (wb_reg_wr),
        .wb_data       (wb_data),
        .ex_valid      (ex_valid),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .ex_rd         (ex_rd),
        .ex_reg_wr     (ex_reg_wr),
        .ex_mem_rd     (ex_mem_rd),
        .ex_store_data (ex_store_data),
        .id_stall_o    (id_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_use_imm = 0; id_uses_rs2 = 0; id_alu_op = 0; id_reg_wr = 0; id_mem_rd = 0;
        mem_rd = 0; mem_reg_wr = 0; mem_result = 0;
        wb_rd = 0; wb_reg_wr = 0; wb_data = 0;
        stall_i = 0; flush_i = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic ui, input logic u2, input logic [3:0] op,
                          input logic rw, input logic mr);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_use_imm = ui; id_uses_rs2 = u2; id_alu_op = op; id_reg_wr = rw; id_mem_rd = mr;
    endtask

    task automatic push(input string nm, input int mask, input logic v, input logic rw,
                        input logic mr, input logic [3:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                        input logic stl);
        exp_t e;
        e.mask = mask; e.valid = v; e.rw = rw; e.mr = mr; e.op = op; e.rd = rd;
        e.a = a; e.b = b; e.sd = sd; e.stl = stl;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares the EX outputs after every active edge that has an expectation queued
    always begin : monitor
        exp_t  e;
        string nm;
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.mask[0]) chk({nm, ".ex_valid"},  32'(ex_valid),  32'(e.valid));
            if (e.mask[1]) chk({nm, ".ex_reg_wr"}, 32'(ex_reg_wr), 32'(e.rw));
            if (e.mask[2]) chk({nm, ".ex_mem_rd"}, 32'(ex_mem_rd), 32'(e.mr));
            if (e.mask[3]) chk({nm, ".alu_op"},    32'(alu_op),    32'(e.op));
            if (e.mask[4]) chk({nm, ".ex_rd"},     32'(ex_rd),     32'(e.rd));
            if (e.mask[5]) chk({nm, ".alu_a"},     alu_a,          e.a);
            if (e.mask[6]) chk({nm, ".alu_b"},     alu_b,          e.b);
            if (e.mask[7]) chk({nm, ".store"},     ex_store_data,  e.sd);
            if (e.mask[8]) chk({nm, ".id_stall"},  32'(id_stall_o), 32'(e.stl));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset.ex_valid", 32'(ex_valid), 32'h0);
        chk("reset.alu_a", alu_a, 32'h0);
        chk("reset.alu_b", alu_b, 32'h0);
        chk("reset.alu_op", 32'(alu_op), 32'h0);
        chk("reset.id_stall", 32'(id_stall_o), 32'h0);

        // ADD x10 = x1 + x2
        @(negedge clk); rst_n = 1'b1; idle();
        set_id(5'd1, 5'd2, 5'd10, 32'h5, 32'h7, 32'h0, 0, 1, 4'b0000, 1, 0);
        push("add", MA, 1, 1, 0, 4'b0000, 5'd10, 32'h5, 32'h7, 32'h7, 0);

        // MEM beats WB for x3, b from immediate
        @(negedge clk); idle();
        set_id(5'd3, 5'd2, 5'd13, 32'h11, 32'h7, 32'h40, 1, 0, 4'b0000, 1, 0);
        mem_reg_wr = 1; mem_rd = 5'd3; mem_result = 32'hAA;
        wb_reg_wr = 1; wb_rd = 5'd3; wb_data = 32'hBB;
        push("fwd_mem", MA, 1, 1, 0, 4'b0000, 5'd13, 32'hAA, 32'h40, 32'h7, 0);

        // MEM not writing: WB supplies x3 on both sources
        @(negedge clk); idle();
        set_id(5'd3, 5'd3, 5'd13, 32'h11, 32'h22, 32'h40, 0, 1, 4'b0000, 1, 0);
        mem_reg_wr = 0; mem_rd = 5'd3; mem_result = 32'hAA;
        wb_reg_wr = 1; wb_rd = 5'd3; wb_data = 32'hBB;
        push("fwd_wb", MA, 1, 1, 0, 4'b0000, 5'd13, 32'hBB, 32'hBB, 32'hBB, 0);

        // x0 stays zero even when MEM/WB claim to write it
        @(negedge clk); idle();
        set_id(5'd0, 5'd5, 5'd14, 32'h99, 32'h55, 32'h0, 0, 1, 4'b0010, 1, 0);
        mem_reg_wr = 1; mem_rd = 5'd0; mem_result = 32'hAA;
        wb_reg_wr = 1; wb_rd = 5'd0; wb_data = 32'hBB;
        push("fwd_x0", MA, 1, 1, 0, 4'b0010, 5'd14, 32'h0, 32'h55, 32'h55, 0);

        // load x4 = mem[x1 + 8]
        @(negedge clk); idle();
        set_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 1, 0, 4'b0000, 1, 1);
        push("load", MA, 1, 1, 1, 4'b0000, 5'd4, 32'h100, 32'h8, 32'h0, 0);

        // SUB x9 = x7 - x4 : load-use on rs2
        @(negedge clk); idle();
        set_id(5'd7, 5'd4, 5'd9, 32'h3, 32'h0, 32'h0, 0, 1, 4'b0001, 1, 0);
        #1 chk("lu.stall_req", 32'(id_stall_o), 32'h1);
        push("lu_bubble", MB, 0, 0, 0, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h0, 0);

        @(negedge clk); idle();
        set_id(5'd7, 5'd4, 5'd9, 32'h3, 32'h0, 32'h0, 0, 1, 4'b0001, 1, 0);
        mem_reg_wr = 1; mem_rd = 5'd4; mem_result = 32'h77;
        push("lu_issue", MA, 1, 1, 0, 4'b0001, 5'd9, 32'h3, 32'h77, 32'h77, 0);

        // ADD x11 reads x6, then held under stall while WB retires x6
        @(negedge clk); idle();
        set_id(5'd6, 5'd0, 5'd11, 32'h5, 32'h0, 32'h0, 0, 0, 4'b0000, 1, 0);
        push("pre_stall", MA, 1, 1, 0, 4'b0000, 5'd11, 32'h5, 32'h0, 32'h0, 0);

        @(negedge clk); idle();
        set_id(5'd1, 5'd0, 5'd15, 32'h9, 32'h0, 32'h0, 0, 0, 4'b0001, 1, 0);
        stall_i = 1; wb_reg_wr = 1; wb_rd = 5'd6; wb_data = 32'h123;
        push("stall_c1", MA, 1, 1, 0, 4'b0000, 5'd11, 32'h123, 32'h0, 32'h0, 1);

        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); idle();
            set_id(5'd1, 5'd0, 5'd15, 32'h9, 32'h0, 32'h0, 0, 0, 4'b0001, 1, 0);
            stall_i = 1;
            push($sformatf("stall_c%0d", c), MA, 1, 1, 0, 4'b0000, 5'd11, 32'h123, 32'h0, 32'h0, 1);
        end

        @(negedge clk); idle();
        set_id(5'd1, 5'd0, 5'd15, 32'h9, 32'h0, 32'h0, 0, 0, 4'b0001, 1, 0);
        #1 chk("release.alu_a", alu_a, 32'h123);
        push("post_stall", MA, 1, 1, 0, 4'b0001, 5'd15, 32'h9, 32'h0, 32'h0, 0);

        // load x4, then a consumer arrives with flush and stall both set
        @(negedge clk); idle();
        set_id(5'd1, 5'd0, 5'd4, 32'h20, 32'h0, 32'h4, 1, 0, 4'b0000, 1, 1);
        push("load2", MA, 1, 1, 1, 4'b0000, 5'd4, 32'h20, 32'h4, 32'h0, 0);

        @(negedge clk); idle();
        set_id(5'd4, 5'd0, 5'd16, 32'h0, 32'h0, 32'h0, 0, 0, 4'b0000, 1, 0);
        stall_i = 1; flush_i = 1;
        #1 chk("flush.stall_req", 32'(id_stall_o), 32'h0);
        push("flush", MB, 0, 0, 0, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h0, 0);

        @(negedge clk); idle();
        push("idle", MB, 0, 0, 0, 4'b0000, 5'd0, 32'h0, 32'h0, 32'h0, 0);

        // Asynchronous reset in the middle of a stalled cycle
        @(negedge clk); idle();
        set_id(5'd1, 5'd2, 5'd12, 32'h5, 32'h7, 32'h0, 0, 1, 4'b0000, 1, 0);
        push("pre_rst", MA, 1, 1, 0, 4'b0000, 5'd12, 32'h5, 32'h7, 32'h7, 0);

        @(negedge clk); idle();
        stall_i = 1;
        #1 chk("pre_rst.stall_req", 32'(id_stall_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst.ex_valid", 32'(ex_valid), 32'h0);
        chk("async_rst.ex_reg_wr", 32'(ex_reg_wr), 32'h0);
        chk("async_rst.alu_a", alu_a, 32'h0);
        chk("async_rst.alu_b", alu_b, 32'h0);
        chk("async_rst.store", ex_store_data, 32'h0);
        chk("async_rst.id_stall", 32'(id_stall_o), 32'h0);

        @(negedge clk); idle(); rst_n = 1'b1;

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
